// File: rtl/mantis_tweak_sched.sv
// rtl/mantis_tweak_sched.sv - Mantis round-tweak scheduler: H forward half, H-inverse backward half
// Optional saved-tweak consistency check enabled by MANTIS_TWEAK_SELFCHECK_EN.
module mantis_tweak_sched #(
  parameter int ROUNDS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] tweak_in,
  input  logic        tk_ready,
  output logic        busy,
  output logic        tk_valid,
  output logic [63:0] tk_out,
  output logic [3:0]  round_idx,
  output logic        bwd,
  output logic        done
`ifdef MANTIS_TWEAK_SELFCHECK_EN
  ,
  output logic        chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;

  localparam logic [3:0]  RLAST    = 4'(ROUNDS);
  // Nibble i of each table is the source nibble index for output nibble i.
  localparam logic [63:0] H_TAB    = 64'hBA98_4DC7_3210_FE56;
  localparam logic [63:0] HINV_TAB = 64'h32A9_FEDC_801B_7654;

  function automatic logic [63:0] nib_perm(input logic [63:0] x, input logic [63:0] tab);
    logic [63:0] y;
    logic [3:0]  sel;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      sel           = tab[4*i +: 4];
      y[4*i +: 4]   = x[{sel, 2'b00} +: 4];
    end
    return y;
  endfunction

  state_t      state_q;
  logic        busy_q;
  logic        tk_valid_q;
  logic [63:0] tk_out_q;
  logic [3:0]  round_q;
  logic        bwd_q;
  logic        done_q;
  logic [63:0] h_d;
  logic [63:0] hinv_d;
  logic        accept;

  assign h_d    = nib_perm(tk_out_q, H_TAB);
  assign hinv_d = nib_perm(tk_out_q, HINV_TAB);
  assign accept = tk_valid_q & tk_ready;

`ifdef MANTIS_TWEAK_SELFCHECK_EN
  logic [63:0] saved_q;
  logic        chk_err_q;
  assign chk_err = chk_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      tk_valid_q <= 1'b0;
      tk_out_q   <= '0;
      round_q    <= '0;
      bwd_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef MANTIS_TWEAK_SELFCHECK_EN
      saved_q    <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FWD;
            busy_q     <= 1'b1;
            tk_valid_q <= 1'b1;
            tk_out_q   <= tweak_in;
            round_q    <= '0;
            bwd_q      <= 1'b0;
`ifdef MANTIS_TWEAK_SELFCHECK_EN
            saved_q    <= tweak_in;
            chk_err_q  <= 1'b0;
`endif
          end
        end
        FWD: begin
          if (accept) begin
            // The turnaround beat repeats H^ROUNDS(T) with bwd set.
            if (round_q == RLAST) begin
              state_q <= BWD;
              bwd_q   <= 1'b1;
            end else begin
              tk_out_q <= h_d;
              round_q  <= round_q + 4'd1;
            end
          end
        end
        BWD: begin
          if (accept) begin
            if (round_q == 4'd0) begin
              state_q    <= IDLE;
              tk_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`ifdef MANTIS_TWEAK_SELFCHECK_EN
              chk_err_q  <= (tk_out_q != saved_q);
`endif
            end else begin
              tk_out_q <= hinv_d;
              round_q  <= round_q - 4'd1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          tk_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign tk_valid  = tk_valid_q;
  assign tk_out    = tk_out_q;
  assign round_idx = round_q;
  assign bwd       = bwd_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mantis_tweak_sched.sv
// tb/tb_mantis_tweak_sched.sv - directed bench for mantis_tweak_sched (ROUNDS=7)
module tb_mantis_tweak_sched;

  localparam int R  = 7;
  localparam int NB = 2*R + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [63:0] tweak_in = '0;
  logic        tk_ready = 1'b0;
  logic        busy;
  logic        tk_valid;
  logic [63:0] tk_out;
  logic [3:0]  round_idx;
  logic        bwd;
  logic        done;
`ifdef MANTIS_TWEAK_SELFCHECK_EN
  logic        chk_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int h_tab[16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};

  mantis_tweak_sched #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tweak_in  (tweak_in),
    .tk_ready  (tk_ready),
    .busy      (busy),
    .tk_valid  (tk_valid),
    .tk_out    (tk_out),
    .round_idx (round_idx),
    .bwd       (bwd),
    .done      (done)
`ifdef MANTIS_TWEAK_SELFCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] h_model(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = x[4*h_tab[i] +: 4];
    return y;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(tk_valid), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic run_sched(input logic [63:0] t, input bit bp, input bit poke_busy,
                           input bit poke_end, input int abort_at);
    logic [63:0] exp_out[NB];
    logic [3:0]  exp_r[NB];
    logic        exp_b[NB];
    logic [63:0] cur, p_out;
    logic [3:0]  p_r;
    logic        p_b;
    bit          stalled;
    int          beats, cyc;
    cur = t;
    for (int b = 0; b <= R; b++) begin
      exp_out[b] = cur;
      exp_r[b]   = 4'(b);
      exp_b[b]   = 1'b0;
      if (b < R) cur = h_model(cur);
    end
    for (int b = R + 1; b < NB; b++) begin
      exp_out[b] = exp_out[NB-1-b];
      exp_r[b]   = exp_r[NB-1-b];
      exp_b[b]   = 1'b1;
    end
    @(negedge clk);
    check("pre_start_valid", 64'(tk_valid), 64'd0);
    tweak_in = t;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    tweak_in = ~t;
    beats = 0; cyc = 0; stalled = 0;
    p_out = '0; p_r = '0; p_b = 1'b0;
    while (beats < NB && cyc < 400) begin
      tk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke_busy && beats == 2) || (poke_end && beats == NB - 1);
      check("valid", 64'(tk_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("done_early", 64'(done), 64'd0);
      if (stalled) begin
        check("hold_out", tk_out, p_out);
        check("hold_round", 64'(round_idx), 64'(p_r));
        check("hold_bwd", 64'(bwd), 64'(p_b));
      end
      if (tk_ready) begin
        check("beat_out", tk_out, exp_out[beats]);
        check("beat_round", 64'(round_idx), 64'(exp_r[beats]));
        check("beat_bwd", 64'(bwd), 64'(exp_b[beats]));
        if (beats == abort_at) begin
          start = 1'b0;
          rst_n = 1'b0;
          #1;
          check("rst_valid", 64'(tk_valid), 64'd0);
          check("rst_busy", 64'(busy), 64'd0);
          check("rst_out", tk_out, 64'd0);
          check("rst_round", 64'(round_idx), 64'd0);
          check("rst_bwd", 64'(bwd), 64'd0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          check_idle("post_rst");
          return;
        end
        stalled = 0;
        beats++;
      end else begin
        stalled = 1;
        p_out = tk_out;
        p_r   = round_idx;
        p_b   = bwd;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("beat_count", 64'(beats), 64'(NB));
    if (!bp) check("done_latency", 64'(cyc), 64'(NB));
    check("done_pulse", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("valid_at_done", 64'(tk_valid), 64'd0);
    @(negedge clk);
    check_idle("after_done");
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(tk_valid), 64'd0);
    check("reset_out", tk_out, 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle("idle");
    check("idle_out", tk_out, 64'd0);

    tweak_in = 64'hFEDCBA9876543210;
    tk_ready = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("step0_out", tk_out, 64'hFEDCBA9876543210);
    check("step0_round", 64'(round_idx), 64'd0);
    check("step0_bwd", 64'(bwd), 64'd0);
    @(negedge clk);
    check("step1_out", tk_out, 64'hBA984DC73210FE56);
    check("step1_round", 64'(round_idx), 64'd1);
    check("step1_bwd", 64'(bwd), 64'd0);
    @(negedge clk);
    check("step2_out", tk_out, 64'h4DC70983FE56BA12);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("step_done", 64'(done), 64'd1);
    check("step_last_out", tk_out, 64'hFEDCBA9876543210);
    @(negedge clk);
    check_idle("step_idle");

    run_sched(64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b1, 99);
    run_sched(64'hFEDCBA9876543210, 1'b1, 1'b0, 1'b0, 99);
    run_sched(64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0, 5);
    run_sched(64'hA5A50F0F3C3C9669, 1'b0, 1'b0, 1'b0, 99);
    run_sched(64'h1122334455667788, 1'b1, 1'b1, 1'b1, 99);

`ifdef MANTIS_TWEAK_SELFCHECK_EN
    check("chk_clean", 64'(chk_err), 64'd0);
    tk_ready = 1'b1;
    tweak_in = 64'h0F1E2D3C4B5A6978;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !bwd; i++) @(negedge clk);
    dut.tk_out_q = dut.tk_out_q ^ 64'h1;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("chk_err_set", 64'(chk_err), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
